dm_spi_multichain: RTL and testbench

DM_SPI_MULTICHAIN -- requirements
Module: dm_spi_multichain

---
 rtl/dm_spi_pkg.sv | 30 +++
 rtl/dm_spi_shifter.sv | 44 ++++
 rtl/dm_spi_multichain.sv | 164 ++++++++++++++++
 tb/tb_dm_spi_multichain.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_spi_pkg.sv
// Shared types, default parameters and width helpers for the multichain SPI master.
package dm_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_HOLD
    } state_t;

    localparam int DEF_NUM_CHAINS = 6;
    localparam int DEF_NUM_CS     = 4;
    localparam int DEF_WORD_BITS  = 24;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CS_SETUP   = 2;
    localparam int DEF_CS_HOLD    = 2;

    // Index width for a range of n values; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dm_spi_shifter.sv
// One chain's transmit register: loads a word, shifts MSB first and gates Mosi
// high whenever the chain is not taking part in the current transfer.
module dm_spi_shifter #(
    parameter int WORD_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic                 i_release,
    input  logic                 i_en,
    input  logic [WORD_BITS-1:0] i_data,
    output logic                 o_mosi
);

    logic [WORD_BITS-1:0] r_sr;
    logic                 r_en;
    logic                 r_mosi;
    logic [WORD_BITS-1:0] w_next;

    assign w_next = r_sr << 1;
    assign o_mosi = r_mosi;

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr   <= '0;
            r_en   <= 1'b0;
            r_mosi <= 1'b1;
        end else if (i_load) begin
            r_sr   <= i_data;
            r_en   <= i_en;
            r_mosi <= i_en ? i_data[WORD_BITS-1] : 1'b1;
        end else if (i_shift) begin
            r_sr   <= w_next;
            r_mosi <= r_en ? w_next[WORD_BITS-1] : 1'b1;
        end else if (i_release) begin
            r_sr   <= '0;
            r_en   <= 1'b0;
            r_mosi <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_spi_multichain.sv
// Multichain SPI master (mode 3): one sequencer drives NUM_CHAINS shifters in
// lockstep, each chain with its own Sck, Mosi and chip-select group.
module dm_spi_multichain
    import dm_spi_pkg::*;
#(
    parameter int NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int NUM_CS     = DEF_NUM_CS,
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_SETUP   = DEF_CS_SETUP,
    parameter int CS_HOLD    = DEF_CS_HOLD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Start,
    input  logic [idx_width(NUM_CS)-1:0]    CsSel,
    input  logic [NUM_CHAINS-1:0]           ChainEn,
    input  logic [NUM_CHAINS*WORD_BITS-1:0] TxData,
    output logic                            Busy,
    output logic                            Done,
    output logic [NUM_CHAINS-1:0]           Sck,
    output logic [NUM_CHAINS-1:0]           Mosi,
    output logic [NUM_CHAINS*NUM_CS-1:0]    nCs
);

    localparam int CS_W  = idx_width(NUM_CS);
    localparam int CNT_W = idx_width(max3(CLK_DIV, CS_SETUP, CS_HOLD));
    localparam int BIT_W = idx_width(WORD_BITS);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);

    if (CLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || NUM_CS < 1 || NUM_CHAINS < 1) begin : g_param_check
        $error("dm_spi_multichain: CLK_DIV, CS_SETUP, CS_HOLD, NUM_CS and NUM_CHAINS must be >= 1");
    end

    state_t                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [BIT_W-1:0]               r_bit;
    logic [NUM_CHAINS-1:0]          r_chain_en;
    logic                           r_busy;
    logic                           r_done;
    logic [NUM_CHAINS-1:0]          r_sck;
    logic [NUM_CHAINS*NUM_CS-1:0]   r_ncs;

    logic                           w_cs_ok;
    logic                           w_load;
    logic                           w_shift;
    logic                           w_release;
    logic [NUM_CHAINS*NUM_CS-1:0]   w_ncs_sel;

    assign w_cs_ok   = ({1'b0, CsSel} < (CS_W + 1)'(NUM_CS));
    assign w_load    = (r_state == S_IDLE) && Start && w_cs_ok;
    // Mosi advances on entry to every SHIFT_LO except the first.
    assign w_shift   = (r_state == S_SHIFT_HI) && (r_cnt == DIV_LAST) && (r_bit != BIT_LAST);
    assign w_release = (r_state == S_HOLD) && (r_cnt == HOLD_LAST);

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_ncs_sel = '1;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            for (int j = 0; j < NUM_CS; j++) begin
                if (ChainEn[i] && (CsSel == CS_W'(j))) begin
                    w_ncs_sel[i*NUM_CS + j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_chain_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= '1;
            r_ncs      <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state    <= S_SETUP;
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_chain_en <= ChainEn;
                        r_busy     <= 1'b1;
                        r_ncs      <= w_ncs_sel;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= S_SHIFT_LO;
                        r_cnt   <= '0;
                        r_sck   <= ~r_chain_en;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT_LO: begin
                    if (r_cnt == DIV_LAST) begin
                        r_state <= S_SHIFT_HI;
                        r_cnt   <= '0;
                        r_sck   <= '1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_SHIFT_LO;
                            r_bit   <= r_bit + BIT_W'(1);
                            r_sck   <= ~r_chain_en;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_ncs      <= '1;
                        r_chain_en <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
        dm_spi_shifter #(
            .WORD_BITS (WORD_BITS)
        ) u_shifter (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_load),
            .i_shift   (w_shift),
            .i_release (w_release),
            .i_en      (ChainEn[g]),
            .i_data    (TxData[g*WORD_BITS +: WORD_BITS]),
            .o_mosi    (Mosi[g])
        );
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Sck  = r_sck;
    assign nCs  = r_ncs;

endmodule

// File: tb/tb_dm_spi_multichain.sv
// Randomized self-checking bench: per-cycle output model derived from transfer
// timing arithmetic, plus a rising-edge slave model per chain.
module tb_dm_spi_multichain;

    localparam int NC = 2;
    localparam int NCS = 4;
    localparam int WB = 8;
    localparam int CD = 2;
    localparam int SU = 1;
    localparam int HO = 1;
    localparam int T  = SU + 2*CD*WB + HO + 1;
    localparam logic [31:0] IDLE_VEC = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          Start;
    logic [1:0]    CsSel;
    logic [NC-1:0] ChainEn;
    logic [15:0]   TxData;
    logic          Busy, Done;
    logic [NC-1:0] Sck, Mosi;
    logic [7:0]    nCs;

    logic          Start3;
    logic [1:0]    CsSel3;
    logic          Busy3, Done3;
    logic [NC-1:0] Sck3, Mosi3;
    logic [5:0]    nCs3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_spi_multichain #(
        .NUM_CHAINS(NC), .NUM_CS(NCS), .WORD_BITS(WB),
        .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO)
    ) u_dut (
        .clk(clk), .rst(rst), .Start(Start), .CsSel(CsSel), .ChainEn(ChainEn),
        .TxData(TxData), .Busy(Busy), .Done(Done), .Sck(Sck), .Mosi(Mosi), .nCs(nCs)
    );

    dm_spi_multichain #(
        .NUM_CHAINS(NC), .NUM_CS(3), .WORD_BITS(WB),
        .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO)
    ) u_dut3 (
        .clk(clk), .rst(rst), .Start(Start3), .CsSel(CsSel3), .ChainEn(ChainEn),
        .TxData(TxData), .Busy(Busy3), .Done(Done3), .Sck(Sck3), .Mosi(Mosi3), .nCs(nCs3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {18'b0, Busy, Done, Sck, nCs, Mosi};
    endfunction

    // Expected {Busy, Done, Sck, nCs, Mosi} k cycles after Start was sampled.
    function automatic logic [31:0] model(input int k, input logic [15:0] tx,
                                          input logic [1:0] en, input logic [1:0] cs,
                                          output logic [1:0] mosi_dc);
        logic       busy, done;
        logic [1:0] sck, mosi;
        logic [7:0] ncs;
        int         s, b;
        busy = 1'b0; done = 1'b0; sck = 2'b11; mosi = 2'b11; ncs = 8'hFF; mosi_dc = 2'b00;
        if (k >= T) begin
            done = (k == T);
        end else begin
            busy = 1'b1;
            for (int c = 0; c < NC; c++)
                if (en[c]) ncs[c*NCS + int'(cs)] = 1'b0;
            if (k <= SU) begin
                for (int c = 0; c < NC; c++)
                    if (en[c]) mosi[c] = tx[c*WB + WB - 1];
            end else if (k <= SU + 2*CD*WB) begin
                s = k - SU - 1;
                b = s / (2*CD);
                for (int c = 0; c < NC; c++) begin
                    if (en[c]) begin
                        mosi[c] = tx[c*WB + WB - 1 - b];
                        if ((s % (2*CD)) < CD) sck[c] = 1'b0;
                    end
                end
            end else begin
                mosi_dc = en;
            end
        end
        return {18'b0, busy, done, sck, ncs, mosi};
    endfunction

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle", obs(), IDLE_VEC);
        end
    endtask

    // Runs one transfer starting at the current negedge; returns at the negedge of
    // the Done cycle so a following call is back-to-back. rst_at>0 resets mid-way.
    task automatic do_xfer(input logic [15:0] tx, input logic [1:0] en,
                           input logic [1:0] cs, input int rst_at);
        logic [1:0]  dc;
        logic [31:0] e, g;
        logic [1:0]  prev_sck;
        logic [7:0]  cap [NC];
        int          edges [NC];
        Start = 1'b1; TxData = tx; ChainEn = en; CsSel = cs;
        prev_sck = 2'b11;
        for (int c = 0; c < NC; c++) begin cap[c] = '0; edges[c] = 0; end
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            if (rst_at != 0 && k == rst_at + 1) begin
                check("rst_mid", obs(), IDLE_VEC);
                rst = 1'b0;
                return;
            end
            e = model(k, tx, en, cs, dc);
            g = obs();
            g[1:0] = g[1:0] | dc;
            e[1:0] = e[1:0] | dc;
            check($sformatf("cyc%0d", k), g, e);
            for (int c = 0; c < NC; c++) begin
                if (!prev_sck[c] && Sck[c] && (nCs[c*NCS +: NCS] != 4'hF)) begin
                    cap[c] = {cap[c][6:0], Mosi[c]};
                    edges[c]++;
                end
            end
            prev_sck = Sck;
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1; Start = 1'b0;
            end else if (k < T) begin
                Start   = (k == 10) ? 1'b1 : 1'($urandom_range(0, 1));
                TxData  = (k == 5) ? 16'hFFFF : 16'($urandom);
                ChainEn = 2'($urandom);
                CsSel   = 2'($urandom);
            end else begin
                Start = 1'b0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            check($sformatf("edges_c%0d", c), edges[c], en[c] ? WB : 0);
            if (en[c]) check($sformatf("word_c%0d", c), {24'b0, cap[c]}, {24'b0, tx[c*WB +: WB]});
        end
    endtask

    initial begin
        int first_done, n_done;
        rst = 1'b1; Start = 1'b0; Start3 = 1'b0; CsSel = '0; CsSel3 = '0;
        ChainEn = '0; TxData = '0;
        repeat (3) @(negedge clk);
        check("reset_state", obs(), IDLE_VEC);
        rst = 1'b0;
        idle_run(2);

        // Start coinciding with reset is dropped
        rst = 1'b1; Start = 1'b1; CsSel = 2'd1; ChainEn = 2'b11;
        @(negedge clk);
        rst = 1'b0; Start = 1'b0;
        check("start_in_rst", obs(), IDLE_VEC);
        idle_run(2);

        // Directed: both chains, cs 2; then back-to-back repeat
        do_xfer(16'h3CA5, 2'b11, 2'd2, 0);
        do_xfer(16'h3CA5, 2'b11, 2'd2, 0);
        idle_run(2);
        do_xfer(16'h3CA5, 2'b01, 2'd0, 0);
        idle_run(1);
        do_xfer(16'h5A5A, 2'b00, 2'd3, 0);
        do_xfer(16'h8001, 2'b10, 2'd1, 0);
        idle_run(1);

        for (int i = 0; i < 20; i++) begin
            do_xfer(16'($urandom), 2'($urandom), 2'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle_run($urandom_range(1, 3));
        end
        idle_run(1);

        // Reset in cycle 12 of a transfer: idle next cycle, no Done afterwards
        do_xfer(16'h3CA5, 2'b11, 2'd2, 12);
        Start = 1'b0;
        idle_run(40);

        // Out-of-range chip select on a 3-select instance is ignored
        ChainEn = 2'b11; Start3 = 1'b1; CsSel3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cs_invalid", {29'b0, Busy3, Done3, 1'b0} | {26'b0, nCs3}, 32'h0000_003F);
        end
        CsSel3 = 2'd1;
        @(negedge clk);
        Start3 = 1'b0;
        check("cs3_start", {25'b0, Busy3, nCs3}, {25'b0, 1'b1, 6'b101101});
        first_done = 0; n_done = 0;
        for (int k = 2; k <= 45; k++) begin
            @(negedge clk);
            if (Done3) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (k == 10) begin Start3 = 1'b1; CsSel3 = 2'd0; end
            if (k == 11) Start3 = 1'b0;
        end
        check("cs3_done_cycle", first_done, T);
        check("cs3_done_count", n_done, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
